regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised multi-port register file with per-register busy scoreboard for the pipelined CPU.
//  ID stage reads operands and issues destinations; writeback stage writes results and clears busy.
//  Generates a stall when a read hits a pending register (RAW) or an issue targets one (WAW).
//  Replaces the fixed 4x16 two-port file and removes the need for NOPs between dependent ops.
// PARAMETERS
//  DATA_W    16  register width in bits
//  NUM_REGS  4   number of architectural registers, >=2
//  RD_PORTS  2   number of independent read ports, >=1
//  ZERO_REG  1   1: register 0 always reads 0, ignores writes and never becomes busy
// PORTS  (AW = clog2(NUM_REGS))
//  clk        in   1                  rising-edge clock
//  rst        in   1                  synchronous reset, active high
//  rd_en      in   RD_PORTS           port i carries a real source operand
//  rd_addr    in   RD_PORTS*AW        port i address, bits [i*AW +: AW]
//  rd_data    out  RD_PORTS*DATA_W    port i data, combinational
//  rd_busy    out  RD_PORTS           port i addresses a pending register
//  issue_vld  in   1                  instruction with destination leaving ID this cycle
//  issue_dst  in   AW                 destination register
//  issue_rdy  out  1                  issue accepted this cycle
//  wb_vld     in   1                  writeback valid
//  wb_addr    in   AW                 writeback register
//  wb_data    in   DATA_W             writeback data
//  stall      out  1                  |(rd_en & rd_busy) | (issue_vld & ~issue_rdy)
//  err_wb     out  1                  sticky: writeback to non-busy register seen
// BEHAVIOUR
//  - Reset: all registers 0, all busy bits 0, err_wb 0; outputs are functions of that state.
//  - Write: on clk rise with wb_vld, reg[wb_addr] <= wb_data, busy[wb_addr] <= 0; visible next cycle.
//  - Read: rd_data[i] = reg[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]]; rd_en only gates stall.
//  - issue_rdy = ~busy[issue_dst] | (wb_vld & wb_addr==issue_dst); one outstanding write per register.
//  - Issue: on clk rise with issue_vld & issue_rdy, busy[issue_dst] <= 1; refused issue changes nothing.
//  - Same-cycle wb and issue to same register: data written, busy ends 1 (issue wins).
//  - wb to non-busy register: data still written, busy stays 0, err_wb <= 1 until rst.
//  - ZERO_REG=1, address 0: rd_data 0, rd_busy 0, writes dropped (no err_wb), issue_rdy 1, busy never set.
//  - Address >= NUM_REGS: reads 0/not busy, writes and issues ignored, issue_rdy 1.
//  - rst asserted mid-operation clears everything on that edge; concurrent wb/issue discarded.
//  - Stall is combinational; the owner holds IF/ID and withholds issue_vld while stall=1.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: when wb_vld & wb_addr==rd_addr[i] (non-zero reg), rd_data[i]=wb_data
//   and rd_busy[i]=0 in the same cycle; RAW resolves with zero stall cycles after writeback.
//  Not defined: rd_data/rd_busy reflect registered state only; one extra stall cycle after writeback.
// STRUCTURE
//  Package regfile_pkg: function clog2, localparam ZERO_ADDR, typedef for busy vector.
//  Sub-module rf_busy_table: busy bits, issue_rdy, set/clear priority, err_wb.
//  Top: storage array, read muxes, bypass (under macro), stall OR.
// TESTING  (defaults: DATA_W=16, NUM_REGS=4, RD_PORTS=2)
//  1. Reset, read all regs -> all rd_data 0, rd_busy 0, stall 0, err_wb 0.
//  2. Issue r1, next cycle rd_en=01, rd_addr0=1 -> stall 1; wb r1=15 -> stall 0 after (bypass: same cycle), rd_data 15.
//  3. Issue r2 twice without wb -> 2nd issue_rdy 0, stall 1; wb r2 + issue r2 same cycle -> issue_rdy 1, busy r2 stays 1.
//  4. wb r0=0x1234, issue r0 -> reads of r0 = 0, rd_busy 0, err_wb 0.
//  5. wb r3=7 with r3 not busy -> r3 reads 7, err_wb 1, stays 1 until rst.
//  6. Busy r1,r2 then rst -> busy cleared, data 0, stall 0 next cycle; rerun 2 with and without REGFILE_BYPASS_EN.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file with busy scoreboard.
package regfile_pkg;

  localparam int unsigned MAX_REGS  = 256;
  localparam int unsigned BUSY_IW   = 8;
  localparam int unsigned ZERO_ADDR = 0;

  // Busy vector sized for the largest supported file; bits >= NUM_REGS read as 0.
  typedef logic [MAX_REGS-1:0] busy_vec_t;

  // Ceiling log2, never below 1 so address ports always have a width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << (i - 1)) < 64'(n)) r = i;
    end
    return r;
  endfunction

  // True when the address names a real register that holds data and can go busy.
  function automatic logic addr_tracked(input int unsigned a, input int unsigned num_regs,
                                        input logic zero_reg);
    return (a < num_regs) && !(zero_reg && (a == ZERO_ADDR));
  endfunction

endpackage

// File: rtl/regfile_scoreboard_busy.sv
// Per-register busy bits: issue sets, writeback clears, issue wins on a same-register tie.
module rf_busy_table
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned AW       = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_issue_vld,
  input  logic [AW-1:0] i_issue_dst,
  input  logic          i_wb_vld,
  input  logic [AW-1:0] i_wb_addr,
  output logic          o_issue_rdy_c,
  output busy_vec_t     o_busy,
  output logic          o_err_wb
);

  logic [NUM_REGS-1:0] r_busy;
  logic                r_err;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_err_nxt;
  logic                w_issue_trk;
  logic                w_wb_trk;

  assign w_issue_trk = addr_tracked(32'(i_issue_dst), NUM_REGS, ZERO_REG != 0);
  assign w_wb_trk    = addr_tracked(32'(i_wb_addr), NUM_REGS, ZERO_REG != 0);

  // Untracked destinations never block; a pending register frees up if written back now.
  always_comb begin
    o_issue_rdy_c = 1'b1;
    if (w_issue_trk) begin
      o_issue_rdy_c = ~r_busy[i_issue_dst] | (i_wb_vld && (i_wb_addr == i_issue_dst));
    end
  end

  // Next busy state: clear on writeback first, then set on accepted issue so issue wins.
  always_comb begin
    w_busy_nxt = r_busy;
    w_err_nxt  = r_err;
    if (i_wb_vld && w_wb_trk) begin
      if (!r_busy[i_wb_addr]) w_err_nxt = 1'b1;
      w_busy_nxt[i_wb_addr] = 1'b0;
    end
    if (i_issue_vld && o_issue_rdy_c && w_issue_trk) begin
      w_busy_nxt[i_issue_dst] = 1'b1;
    end
  end

  // Busy and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign o_busy   = busy_vec_t'(r_busy);
  assign o_err_wb = r_err;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with busy scoreboard and RAW/WAW stall generation.
// Optional same-cycle writeback bypass to read ports: define REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = 16,
  parameter  int unsigned NUM_REGS = 4,
  parameter  int unsigned RD_PORTS = 2,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RD_PORTS-1:0]        rd_en,
  input  logic [RD_PORTS*AW-1:0]     rd_addr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [RD_PORTS-1:0]        rd_busy,
  input  logic                       issue_vld,
  input  logic [AW-1:0]              issue_dst,
  output logic                       issue_rdy,
  input  logic                       wb_vld,
  input  logic [AW-1:0]              wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       stall,
  output logic                       err_wb
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  busy_vec_t         w_busy;
  logic              w_wb_trk;

  assign w_wb_trk = addr_tracked(32'(wb_addr), NUM_REGS, ZERO_REG != 0);

  rf_busy_table #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk           (clk),
    .rst           (rst),
    .i_issue_vld   (issue_vld),
    .i_issue_dst   (issue_dst),
    .i_wb_vld      (wb_vld),
    .i_wb_addr     (wb_addr),
    .o_issue_rdy_c (issue_rdy),
    .o_busy        (w_busy),
    .o_err_wb      (err_wb)
  );

  // Register storage; the zero register and out-of-range addresses are never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_mem[i] <= '0;
    end else if (wb_vld && w_wb_trk) begin
      r_mem[wb_addr] <= wb_data;
    end
  end

  // Read muxes; untracked addresses read as zero and not busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < int'(RD_PORTS); i++) begin
      logic [AW-1:0] w_a;
      w_a = rd_addr[i*AW +: AW];
      if (addr_tracked(32'(w_a), NUM_REGS, ZERO_REG != 0)) begin
        rd_data[i*DATA_W +: DATA_W] = r_mem[w_a];
        rd_busy[i]                  = w_busy[BUSY_IW'(w_a)];
`ifdef REGFILE_BYPASS_EN
        if (wb_vld && (wb_addr == w_a)) begin
          rd_data[i*DATA_W +: DATA_W] = wb_data;
          rd_busy[i]                  = 1'b0;
        end
`else
`endif
      end
    end
  end

  // Stall on a real operand that is pending or on a refused issue.
  assign stall = (|(rd_en & rd_busy)) | (issue_vld & ~issue_rdy);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard at default parameters.
// Expectations that depend on REGFILE_BYPASS_EN follow the same macro.
module tb_regfile_scoreboard;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned RD_PORTS = 2;
  localparam int unsigned AW       = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [RD_PORTS-1:0]        rd_en;
  logic [RD_PORTS*AW-1:0]     rd_addr;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_busy;
  logic                       issue_vld;
  logic [AW-1:0]              issue_dst;
  logic                       issue_rdy;
  logic                       wb_vld;
  logic [AW-1:0]              wb_addr;
  logic [DATA_W-1:0]          wb_data;
  logic                       stall;
  logic                       err_wb;

  int n_checks = 0;
  int n_errors = 0;

  regfile_scoreboard #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RD_PORTS (RD_PORTS),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .issue_vld (issue_vld),
    .issue_dst (issue_dst),
    .issue_rdy (issue_rdy),
    .wb_vld    (wb_vld),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .stall     (stall),
    .err_wb    (err_wb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_vld = 1'b0;
    wb_vld    = 1'b0;
    rd_en     = '0;
  endtask

  initial begin
    rst = 1'b1; rd_en = '0; rd_addr = '0; issue_vld = 1'b0; issue_dst = '0;
    wb_vld = 1'b0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    rst = 1'b0;

    // 1. reset state across all registers
    rd_en = 2'b11; rd_addr = {2'd1, 2'd0}; #1;
    chk("rst_data_r1r0", 32'(rd_data), 32'h0);
    chk("rst_busy_r1r0", 32'(rd_busy), 32'h0);
    rd_addr = {2'd3, 2'd2}; #1;
    chk("rst_data_r3r2", 32'(rd_data), 32'h0);
    chk("rst_busy_r3r2", 32'(rd_busy), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_err", 32'(err_wb), 32'h0);
    chk("rst_issue_rdy", 32'(issue_rdy), 32'h1);

    // 2. RAW on r1
    rd_en = '0; issue_vld = 1'b1; issue_dst = 2'd1; #1;
    chk("raw_issue_rdy", 32'(issue_rdy), 32'h1);
    tick();
    idle(); rd_en = 2'b01; rd_addr = {2'd0, 2'd1}; #1;
    chk("raw_busy", 32'(rd_busy), 32'h1);
    chk("raw_stall", 32'(stall), 32'h1);
    tick();
    wb_vld = 1'b1; wb_addr = 2'd1; wb_data = 16'd15; #1;
`ifdef REGFILE_BYPASS_EN
    chk("raw_wb_stall", 32'(stall), 32'h0);
    chk("raw_wb_data", 32'(rd_data[15:0]), 32'd15);
`else
    chk("raw_wb_stall", 32'(stall), 32'h1);
    chk("raw_wb_data", 32'(rd_data[15:0]), 32'd0);
`endif
    tick();
    wb_vld = 1'b0; #1;
    chk("raw_after_stall", 32'(stall), 32'h0);
    chk("raw_after_data", 32'(rd_data[15:0]), 32'd15);
    chk("raw_after_busy", 32'(rd_busy), 32'h0);

    // 3. WAW on r2
    idle(); issue_vld = 1'b1; issue_dst = 2'd2; #1;
    chk("waw_first_rdy", 32'(issue_rdy), 32'h1);
    tick();
    #1;
    chk("waw_second_rdy", 32'(issue_rdy), 32'h0);
    chk("waw_second_stall", 32'(stall), 32'h1);
    tick();
    wb_vld = 1'b1; wb_addr = 2'd2; wb_data = 16'h00AA; #1;
    chk("waw_wb_issue_rdy", 32'(issue_rdy), 32'h1);
    chk("waw_wb_issue_stall", 32'(stall), 32'h0);
    tick();
    idle(); rd_addr = {2'd2, 2'd0}; #1;
    chk("waw_busy_kept", 32'(rd_busy), 32'h2);
    chk("waw_data", 32'(rd_data[31:16]), 32'h00AA);
    chk("waw_stall_rd_off", 32'(stall), 32'h0);
    rd_en = 2'b10; #1;
    chk("waw_stall_rd_on", 32'(stall), 32'h1);
    wb_vld = 1'b1; wb_addr = 2'd2; wb_data = 16'h0BB; #1;
`ifdef REGFILE_BYPASS_EN
    chk("waw_wb2_stall", 32'(stall), 32'h0);
`else
    chk("waw_wb2_stall", 32'(stall), 32'h1);
`endif
    tick();
    idle(); #1;
    chk("waw_final_busy", 32'(rd_busy), 32'h0);
    chk("waw_final_data", 32'(rd_data[31:16]), 32'h0BB);
    chk("waw_no_err", 32'(err_wb), 32'h0);

    // 4. zero register ignores writes and issues
    wb_vld = 1'b1; wb_addr = 2'd0; wb_data = 16'h1234;
    issue_vld = 1'b1; issue_dst = 2'd0; rd_en = 2'b01; rd_addr = {2'd0, 2'd0}; #1;
    chk("zero_issue_rdy", 32'(issue_rdy), 32'h1);
    chk("zero_wb_cycle_data", 32'(rd_data[15:0]), 32'h0);
    tick();
    idle(); rd_en = 2'b11; #1;
    chk("zero_data", 32'(rd_data), 32'h0);
    chk("zero_busy", 32'(rd_busy), 32'h0);
    chk("zero_stall", 32'(stall), 32'h0);
    chk("zero_err", 32'(err_wb), 32'h0);

    // 5. writeback to a non-busy register
    idle(); wb_vld = 1'b1; wb_addr = 2'd3; wb_data = 16'd7; rd_addr = {2'd3, 2'd0}; #1;
    chk("err_before_edge", 32'(err_wb), 32'h0);
    tick();
    idle(); #1;
    chk("err_data", 32'(rd_data[31:16]), 32'd7);
    chk("err_set", 32'(err_wb), 32'h1);
    tick(); tick();
    chk("err_sticky", 32'(err_wb), 32'h1);

    // 6. reset mid-operation
    issue_vld = 1'b1; issue_dst = 2'd1; tick();
    issue_dst = 2'd2; tick();
    idle(); rd_en = 2'b11; rd_addr = {2'd2, 2'd1}; #1;
    chk("pre_rst_busy", 32'(rd_busy), 32'h3);
    chk("pre_rst_stall", 32'(stall), 32'h1);
    rst = 1'b1; wb_vld = 1'b1; wb_addr = 2'd3; wb_data = 16'h55;
    issue_vld = 1'b1; issue_dst = 2'd3;
    tick();
    rst = 1'b0; idle(); rd_en = 2'b11; #1;
    chk("post_rst_busy", 32'(rd_busy), 32'h0);
    chk("post_rst_stall", 32'(stall), 32'h0);
    chk("post_rst_data_r2r1", 32'(rd_data), 32'h0);
    chk("post_rst_err", 32'(err_wb), 32'h0);
    rd_addr = {2'd3, 2'd3}; #1;
    chk("post_rst_r3_data", 32'(rd_data), 32'h0);
    chk("post_rst_r3_busy", 32'(rd_busy), 32'h0);

    // 6b. rerun RAW after reset
    idle(); issue_vld = 1'b1; issue_dst = 2'd1; tick();
    idle(); rd_en = 2'b01; rd_addr = {2'd0, 2'd1}; #1;
    chk("rerun_stall", 32'(stall), 32'h1);
    wb_vld = 1'b1; wb_addr = 2'd1; wb_data = 16'd15; #1;
`ifdef REGFILE_BYPASS_EN
    chk("rerun_wb_stall", 32'(stall), 32'h0);
`else
    chk("rerun_wb_stall", 32'(stall), 32'h1);
`endif
    tick();
    idle(); rd_en = 2'b01; #1;
    chk("rerun_after_stall", 32'(stall), 32'h0);
    chk("rerun_after_data", 32'(rd_data[15:0]), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
